// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MIPS EX-stage MULT/MULTU and restoring DIV/DIVU controller with HI/LO write port.
// Defining MDU_MUL_2CYC_EN registers the product and adds the MUL_RUN state.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       op_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o
);
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam int CW = $clog2(WIDTH);
`ifdef MDU_MUL_2CYC_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE, MUL_RUN} state_t;
  logic [2*WIDTH-1:0] prod_q;
`else
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;
`endif
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q, hi_q, lo_q;
  logic               qneg_q, rneg_q;
  logic               mul_op, div_op, sgn, go, ge, mul_fin, div_fin, stall_raw;
  logic [2*WIDTH-1:0] ax, bx, prod, mul_res;
  logic [WIDTH-1:0]   abs_a, abs_b, rem_res, quo_res, res_hi, res_lo;
  logic [WIDTH:0]     rem_sh, diff;
  always_comb begin
    mul_op    = (op_i == EXE_MULT_OP) || (op_i == EXE_MULTU_OP);
    div_op    = (op_i == EXE_DIV_OP) || (op_i == EXE_DIVU_OP);
    sgn       = (op_i == EXE_MULT_OP) || (op_i == EXE_DIV_OP);
    ax        = {{WIDTH{sgn & src_a_i[WIDTH-1]}}, src_a_i};
    bx        = {{WIDTH{sgn & src_b_i[WIDTH-1]}}, src_b_i};
    prod      = ax * bx;
    abs_a     = (sgn & src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    abs_b     = (sgn & src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
    // one restoring step: shift {rem, quo} left, trial-subtract the divisor
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    ge        = ~diff[WIDTH];
    rem_res   = rneg_q ? -rem_q : rem_q;
    quo_res   = qneg_q ? -quo_q : quo_q;
    go        = (state_q == IDLE) & start_i & ~flush_i;
    div_fin   = (state_q == DIV_DONE) & ~flush_i;
`ifdef MDU_MUL_2CYC_EN
    mul_fin   = (state_q == MUL_RUN) & ~flush_i;
    mul_res   = prod_q;
    stall_raw = (go & (div_op | mul_op)) | (state_q == DIV_RUN);
`else
    mul_fin   = go & mul_op;
    mul_res   = prod;
    stall_raw = (go & div_op) | (state_q == DIV_RUN);
`endif
    res_hi    = (state_q == DIV_DONE) ? rem_res : mul_res[2*WIDTH-1:WIDTH];
    res_lo    = (state_q == DIV_DONE) ? quo_res : mul_res[WIDTH-1:0];
    // gated by resetn so a reset mid-operation silences outputs at once
    done_o    = resetn & (mul_fin | div_fin);
    stall_o   = resetn & stall_raw;
    hi_o      = done_o ? res_hi : hi_q;
    lo_o      = done_o ? res_lo : lo_q;
    busy_o    = state_q != IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_MUL_2CYC_EN
      prod_q  <= '0;
`endif
    end else begin
      if (done_o) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (flush_i) state_q <= IDLE;
      else begin
        case (state_q)
          IDLE: begin
            if (start_i & div_op) begin
              state_q <= DIV_RUN;
              rem_q   <= '0;
              cnt_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              qneg_q  <= sgn & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
              rneg_q  <= sgn & src_a_i[WIDTH-1];
            end
`ifdef MDU_MUL_2CYC_EN
            else if (start_i & mul_op) begin
              state_q <= MUL_RUN;
              prod_q  <= prod;
            end
`endif
          end
          DIV_RUN: begin
            rem_q <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ge};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_q <= DIV_DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
